// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard scoreboard.
package pipe_hazard_pkg;

   // Default number of stages after ID that can forward (EX, MEM, WB).
   localparam int FWD_STAGES_DEF = 3;

   // Storage widths of a scoreboard entry. These are upper bounds:
   // REG_AW must not exceed RD_W_MAX and LOAD_LAT must fit in LAT_W bits.
   localparam int RD_W_MAX = 8;
   localparam int LAT_W    = 4;

   // Operand select value meaning "take the operand from the register file".
   localparam int SEL_RF = 0;

   // One in-flight writer: valid, destination, writes-RD flag, cycles until forwardable.
   typedef struct packed {
      logic                v;
      logic [RD_W_MAX-1:0] rd;
      logic                wr;
      logic [LAT_W-1:0]    lat;
   } sb_entry_t;

   // Width of an operand select able to encode 0 (RF) up to 'stages'.
   function automatic int sel_w(input int stages);
      int w;
      w = $clog2(stages + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage side bundle of the hazard scoreboard: decoded operands in,
// pipeline control and operand selects out.
interface pipe_hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 16
);
   logic              ID_VALID;
   logic [REG_AW-1:0] ID_RA;
   logic [REG_AW-1:0] ID_RB;
   logic [1:0]        ID_SR;
   logic [REG_AW-1:0] ID_RD;
   logic              ID_RF_LE;
   logic              ID_L;
   logic              BR_TAKEN;
   logic              LE;
   logic              NOP;
   logic              FLUSH;
   logic [SEL_W-1:0]  A_S;
   logic [SEL_W-1:0]  B_S;
   logic [CNT_W-1:0]  STALL_CNT;

   // Pipeline / decode side.
   modport master (
      output ID_VALID, ID_RA, ID_RB, ID_SR, ID_RD, ID_RF_LE, ID_L, BR_TAKEN,
      input  LE, NOP, FLUSH, A_S, B_S, STALL_CNT
   );

   // Scoreboard side.
   modport slave (
      input  ID_VALID, ID_RA, ID_RB, ID_SR, ID_RD, ID_RF_LE, ID_L, BR_TAKEN,
      output LE, NOP, FLUSH, A_S, B_S, STALL_CNT
   );
endinterface

// File: rtl/pipe_hazard_operand.sv
// Single-operand lookup: finds the youngest in-flight writer of the operand
// register and returns a forwarding select or a hazard flag.
module pipe_hazard_operand
   import pipe_hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = FWD_STAGES_DEF,
   parameter int FWD_EN     = 1,
   parameter int SEL_W      = sel_w(FWD_STAGES)
) (
   input  logic              use_i,
   input  logic [REG_AW-1:0] addr_i,
   input  sb_entry_t         sb_i [1:FWD_STAGES],
   output logic [SEL_W-1:0]  sel_o,
   output logic              haz_o
);

   logic [SEL_W-1:0] sel_s;
   logic             haz_s;
   logic             found_s;

   // Priority search from EX outward; the first (youngest) match decides,
   // even when an older writer of the same register is already ready.
   always_comb begin
      sel_s   = SEL_W'(SEL_RF);
      haz_s   = 1'b0;
      found_s = 1'b0;
      if (use_i && (addr_i != '0)) begin
         for (int k = 1; k <= FWD_STAGES; k++) begin
            if (!found_s && sb_i[k].v && sb_i[k].wr &&
                (sb_i[k].rd == RD_W_MAX'(addr_i))) begin
               found_s = 1'b1;
               if ((FWD_EN != 0) && (sb_i[k].lat == '0)) begin
                  sel_s = SEL_W'(k);
               end else begin
                  haz_s = 1'b1;
               end
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         sel_s = SEL_W'(SEL_RF);
      end
   end

   assign sel_o = sel_s;
   assign haz_o = haz_s;

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage: shift-register record of in-flight
// writers EX..WB, operand forwarding selects, load-use / no-forward stalls,
// taken-branch flush and a saturating stall-cycle counter.
module pipe_hazard_scoreboard
   import pipe_hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = FWD_STAGES_DEF,
   parameter int LOAD_LAT   = 1,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   pipe_hazard_scoreboard_if.slave bus
);

   localparam int SEL_W = sel_w(FWD_STAGES);

   sb_entry_t        sb_q [1:FWD_STAGES];
   sb_entry_t        sb_d [1:FWD_STAGES];
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   logic [SEL_W-1:0] sel_a_s;
   logic [SEL_W-1:0] sel_b_s;
   logic             haz_a_s;
   logic             haz_b_s;
   logic             br_s;
   logic             stall_s;
   logic             le_s;
   logic             nop_s;
   logic             flush_s;
   logic [SEL_W-1:0] a_s_s;
   logic [SEL_W-1:0] b_s_s;

   pipe_hazard_operand #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .FWD_EN     (FWD_EN),
      .SEL_W      (SEL_W)
   ) u_op_a (
      .use_i  (bus.ID_SR[1]),
      .addr_i (bus.ID_RA),
      .sb_i   (sb_q),
      .sel_o  (sel_a_s),
      .haz_o  (haz_a_s)
   );

   pipe_hazard_operand #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .FWD_EN     (FWD_EN),
      .SEL_W      (SEL_W)
   ) u_op_b (
      .use_i  (bus.ID_SR[0]),
      .addr_i (bus.ID_RB),
      .sb_i   (sb_q),
      .sel_o  (sel_b_s),
      .haz_o  (haz_b_s)
   );

   // Pipeline control: a taken branch overrides a stall; a branch seen while
   // in reset is ignored so the outputs sit at their idle values.
   always_comb begin
      br_s    = bus.BR_TAKEN & RST;
      stall_s = bus.ID_VALID & (haz_a_s | haz_b_s);
      le_s    = 1'b1;
      nop_s   = 1'b0;
      flush_s = 1'b0;
      if (br_s) begin
         le_s    = 1'b1;
         nop_s   = 1'b1;
         flush_s = 1'b1;
      end else if (stall_s) begin
         le_s    = 1'b0;
         nop_s   = 1'b1;
         flush_s = 1'b0;
      end else begin
         le_s    = 1'b1;
         nop_s   = 1'b0;
         flush_s = 1'b0;
      end
      if (stall_s) begin
         a_s_s = SEL_W'(SEL_RF);
         b_s_s = SEL_W'(SEL_RF);
      end else begin
         a_s_s = sel_a_s;
         b_s_s = sel_b_s;
      end
   end

   // Next scoreboard contents and stall count; the back end never stalls,
   // so entries shift every cycle and a held or flushed ID injects a bubble.
   always_comb begin
      sb_d[1] = '0;
      if (bus.ID_VALID && !stall_s && !br_s) begin
         sb_d[1].v   = 1'b1;
         sb_d[1].rd  = RD_W_MAX'(bus.ID_RD);
         sb_d[1].wr  = bus.ID_RF_LE & (bus.ID_RD != '0);
         sb_d[1].lat = bus.ID_L ? LAT_W'(LOAD_LAT) : '0;
      end else begin
         sb_d[1] = '0;
      end
      for (int k = 2; k <= FWD_STAGES; k++) begin
         sb_d[k] = sb_q[k-1];
         if (sb_q[k-1].lat != '0) begin
            sb_d[k].lat = sb_q[k-1].lat - LAT_W'(1);
         end else begin
            sb_d[k].lat = '0;
         end
      end
      if (stall_s && !br_s && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Scoreboard and counter registers; reset empties the scoreboard, which
   // drops any pending stall immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 1; k <= FWD_STAGES; k++) begin
            sb_q[k] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         for (int k = 1; k <= FWD_STAGES; k++) begin
            sb_q[k] <= sb_d[k];
         end
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.LE        = le_s;
   assign bus.NOP       = nop_s;
   assign bus.FLUSH     = flush_s;
   assign bus.A_S       = a_s_s;
   assign bus.B_S       = b_s_s;
   assign bus.STALL_CNT = stall_cnt_q;

endmodule
